// File: rtl/dircc_msg_pkg.sv
// Shared constants for the inbound message writer: defaults, header layout, FSM encodings.
package dircc_msg_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned DEF_ADDR_W     = 13;
  localparam int unsigned DEF_BASE_ADDR  = 32'h1000;
  localparam int unsigned DEF_NUM_SLOTS  = 16;
  localparam int unsigned DEF_SLOT_WORDS = 32;

  // Slot header word layout, shared with the software header parser
  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned LEN_W     = 16;
  localparam int unsigned TRUNC_BIT = 31;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PAYLOAD = 2'd1;
  localparam logic [1:0] ST_HEADER  = 2'd2;
  localparam logic [1:0] ST_DROP    = 2'd3;

  // Build the slot header word from the truncation flag and received beat count
  function automatic logic [DATA_W-1:0] make_hdr(input logic trunc, input logic [LEN_W-1:0] len);
    logic [DATA_W-1:0] h;
    h = '0;
    h[TRUNC_BIT] = trunc;
    h[LEN_LSB +: LEN_W] = len;
    return h;
  endfunction

endpackage

// File: rtl/dircc_node_mem_msg_writer_if.sv
// Inbound word stream plus node RAM write port; master = stream source/RAM side, slave = writer.
interface dircc_node_mem_msg_writer_if
  import dircc_msg_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_sop;
  logic              in_eop;
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [DATA_W-1:0] mem_writedata;
  logic              mem_clken;

  modport master (
    output in_valid, in_data, in_sop, in_eop,
    input  in_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken
  );

  modport slave (
    input  in_valid, in_data, in_sop, in_eop,
    output in_ready, mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken
  );
endinterface

// File: rtl/dircc_slot_ring_ctrl.sv
// Slot ring bookkeeping: fill pointer, occupancy count and commit/release arbitration.
module dircc_slot_ring_ctrl #(
  parameter  int unsigned NUM_SLOTS = 16,
  localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS),
  localparam int unsigned CNT_W     = SLOT_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic              slot_release,
  output logic [SLOT_W-1:0] wr_slot,
  output logic [CNT_W-1:0]  msg_count,
  output logic              msg_pending,
  output logic              full_c
);

  logic             rel_ok;
  logic [CNT_W-1:0] count_nxt;

  assign full_c = (msg_count == CNT_W'(NUM_SLOTS));

  // Next occupancy: a commit and a release in the same cycle cancel out
  always_comb begin
    rel_ok    = slot_release && (msg_count != '0);
    count_nxt = msg_count;
    if (commit && !rel_ok) begin
      count_nxt = msg_count + CNT_W'(1);
    end else if (!commit && rel_ok) begin
      count_nxt = msg_count - CNT_W'(1);
    end
  end

  // Pointer wraps naturally because NUM_SLOTS is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_slot     <= '0;
      msg_count   <= '0;
      msg_pending <= 1'b0;
    end else begin
      if (commit) begin
        wr_slot <= wr_slot + SLOT_W'(1);
      end
      msg_count   <= count_nxt;
      msg_pending <= (count_nxt != '0);
    end
  end

endmodule

// File: rtl/dircc_node_mem_msg_writer.sv
// Inbound message DMA: writes each stream message into a ring slot of node RAM with a length header.
module dircc_node_mem_msg_writer
  import dircc_msg_pkg::*;
#(
  parameter  int unsigned ADDR_W     = DEF_ADDR_W,
  parameter  int unsigned BASE_ADDR  = DEF_BASE_ADDR,
  parameter  int unsigned NUM_SLOTS  = DEF_NUM_SLOTS,
  parameter  int unsigned SLOT_WORDS = DEF_SLOT_WORDS,
  localparam int unsigned SLOT_W     = $clog2(NUM_SLOTS),
  localparam int unsigned CNT_W      = SLOT_W + 1
) (
  input  logic                         clk,
  input  logic                         reset,
  dircc_node_mem_msg_writer_if.slave   bus,
  input  logic                         slot_release,
  output logic [CNT_W-1:0]             msg_count,
  output logic [SLOT_W-1:0]            wr_slot,
  output logic                         msg_pending,
  output logic [15:0]                  drop_count
);

  localparam int unsigned SLOT_SH = $clog2(SLOT_WORDS);

  logic [1:0]        state_q, state_nxt;
  logic [LEN_W-1:0]  idx_q, idx_nxt;
  logic              trunc_q, trunc_nxt;
  logic              mem_wr_nxt;
  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [DATA_W-1:0] mem_data_nxt;
  logic              commit_c;
  logic              drop_inc_c;
  logic              full_c;
  logic              accept_c;
  logic [ADDR_W-1:0] slot_base_c;

  assign accept_c    = bus.in_valid && bus.in_ready;
  assign slot_base_c = ADDR_W'(BASE_ADDR) + (ADDR_W'(wr_slot) << SLOT_SH);
  assign bus.mem_clken = 1'b1;

  dircc_slot_ring_ctrl #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_ring (
    .clk          (clk),
    .reset        (reset),
    .commit       (commit_c),
    .slot_release (slot_release),
    .wr_slot      (wr_slot),
    .msg_count    (msg_count),
    .msg_pending  (msg_pending),
    .full_c       (full_c)
  );

  // Next-state, beat placement and write-port decode
  always_comb begin
    state_nxt    = state_q;
    idx_nxt      = idx_q;
    trunc_nxt    = trunc_q;
    mem_wr_nxt   = 1'b0;
    mem_addr_nxt = '0;
    mem_data_nxt = '0;
    commit_c     = 1'b0;
    drop_inc_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept_c && bus.in_sop) begin
          if (full_c) begin
            if (bus.in_eop) begin
              drop_inc_c = 1'b1;
            end else begin
              state_nxt = ST_DROP;
            end
          end else begin
            mem_wr_nxt   = 1'b1;
            mem_addr_nxt = slot_base_c + ADDR_W'(1);
            mem_data_nxt = bus.in_data;
            idx_nxt      = LEN_W'(1);
            trunc_nxt    = 1'b0;
            state_nxt    = bus.in_eop ? ST_HEADER : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (accept_c) begin
          // Word offset 0 holds the header, so payload room is SLOT_WORDS-1 beats
          if (idx_q < LEN_W'(SLOT_WORDS - 1)) begin
            mem_wr_nxt   = 1'b1;
            mem_addr_nxt = slot_base_c + ADDR_W'(1) + ADDR_W'(idx_q);
            mem_data_nxt = bus.in_data;
          end else begin
            trunc_nxt = 1'b1;
          end
          if (idx_q != '1) begin
            idx_nxt = idx_q + LEN_W'(1);
          end
          if (bus.in_eop) begin
            state_nxt = ST_HEADER;
          end
        end
      end
      ST_HEADER: begin
        mem_wr_nxt   = 1'b1;
        mem_addr_nxt = slot_base_c;
        mem_data_nxt = make_hdr(trunc_q, idx_q);
        commit_c     = 1'b1;
        state_nxt    = ST_IDLE;
      end
      ST_DROP: begin
        if (accept_c && bus.in_eop) begin
          drop_inc_c = 1'b1;
          state_nxt  = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State, message tracking and registered RAM port
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= ST_IDLE;
      idx_q              <= '0;
      trunc_q            <= 1'b0;
      bus.in_ready       <= 1'b0;
      bus.mem_address    <= '0;
      bus.mem_chipselect <= 1'b0;
      bus.mem_write      <= 1'b0;
      bus.mem_byteenable <= 4'h0;
      bus.mem_writedata  <= '0;
    end else begin
      state_q            <= state_nxt;
      idx_q              <= idx_nxt;
      trunc_q            <= trunc_nxt;
      bus.in_ready       <= (state_nxt != ST_HEADER);
      bus.mem_address    <= mem_addr_nxt;
      bus.mem_chipselect <= mem_wr_nxt;
      bus.mem_write      <= mem_wr_nxt;
      bus.mem_byteenable <= {4{mem_wr_nxt}};
      bus.mem_writedata  <= mem_data_nxt;
    end
  end

  // Saturating count of messages dropped because the ring was full
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_count <= '0;
    end else if (drop_inc_c && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule
